instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 115 +++++++++++
 tb/tb_instr_fetch_mem.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a one-cycle registered fetch port.
// Define IMEM_ALIGN_CHECK_EN to flag misaligned fetches and return NOP_WORD for them.
module instr_fetch_mem #(
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  output logic              ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              oob,
  output logic              misalign
);

  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic [31:0] mem_q [DEPTH];

  logic              state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              oob_q, oob_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] word_idx;
  logic              fetch_oob;
  logic              fetch_mis;
  logic [31:0]       rd_word;
  logic              mem_we;

  assign word_idx  = pc >> 2;
  assign fetch_oob = word_idx >= ADDR_W'(DEPTH);

`ifdef IMEM_ALIGN_CHECK_EN
  assign fetch_mis = |pc[1:0];
`else
  assign fetch_mis = 1'b0;
`endif

  // Words are stored as loaded; byte 0 of a word is bits [31:24].
  assign rd_word = (fetch_oob || fetch_mis) ? NOP_WORD
                                            : mem_q[word_idx[AW-1:0]];

  assign mem_we = rst && (state_q == ST_LOAD) && load_en;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;
    oob_d   = oob_q;
    mis_d   = mis_q;
    if (state_q == ST_LOAD) begin
      valid_d = 1'b0;
      if (load_done) state_d = ST_RUN;
    end else if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (fetch_req) begin
        instr_d = rd_word;
        valid_d = 1'b1;
        ipc_d   = pc;
        oob_d   = fetch_oob;
        mis_d   = fetch_mis;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      instr_q <= '0;
      valid_q <= 1'b0;
      ipc_q   <= '0;
      oob_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
      oob_q   <= oob_d;
      mis_q   <= mis_d;
    end
  end

  // Memory is not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[load_addr] <= load_data;
  end

  assign ready       = (state_q == ST_RUN);
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;
  assign oob         = oob_q;
  assign misalign    = mis_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: driver queues expected fetch
// results, a negedge monitor pops one per valid output cycle.
module tb_instr_fetch_mem;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'hE1A00000;

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              oob;
    logic              mis;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [AW-1:0]     load_addr;
  logic [31:0]       load_data;
  logic              load_done;
  logic              ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              flush;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic              oob;
  logic              misalign;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  instr_fetch_mem #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .ready(ready), .fetch_req(fetch_req), .pc(pc),
    .stall(stall), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .oob(oob), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [ADDR_W-1:0] p,
                      input logic o, input logic m);
    exp_t e;
    e.instr = i; e.pc = p; e.oob = o; e.mis = m;
    sb.push_back(e);
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    step();
  endtask

  // Monitor: every valid output cycle consumes one expectation.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: instr=%h pc=%h", instruction, instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (instruction !== e.instr || instr_pc !== e.pc ||
            oob !== e.oob || misalign !== e.mis) begin
          failures++;
          $display("FAIL fetch: got instr=%h pc=%h oob=%b mis=%b expected instr=%h pc=%h oob=%b mis=%b",
                   instruction, instr_pc, oob, misalign,
                   e.instr, e.pc, e.oob, e.mis);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    load_done = 1'b0; fetch_req = 1'b0; pc = '0;
    stall = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_oob", 32'(oob), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);

    rst = 1'b1;
    fetch_req = 1'b1;
    load(0, 32'hE3A00014);
    fetch_req = 1'b0;
    chk("load_fetch_ignored", 32'(instr_valid), 32'd0);
    load(1, 32'hE3A01A01);
    load(2, 32'hE3A02103);
    load(63, 32'h12345678);
    load_done = 1'b1;
    load(3, 32'hE0923002);
    load_en = 1'b0; load_done = 1'b0;
    chk("ready_after_done", 32'(ready), 32'd1);

    // load_en in RUN must not corrupt word 0
    load_en = 1'b1; load_addr = '0; load_data = 32'hDEADBEEF;
    fetch_req = 1'b1; pc = 8;
    push(32'hE3A02103, 8, 1'b0, 1'b0);
    step();
    load_en = 1'b0; fetch_req = 1'b0;
    step();
    chk("idle_valid", 32'(instr_valid), 32'd0);

    fetch_req = 1'b1; pc = 12;
    push(32'hE0923002, 12, 1'b0, 1'b0);
    step();
    pc = 4;
    push(32'hE3A01A01, 4, 1'b0, 1'b0);
    step();
    stall = 1'b1; pc = 12;
    for (int i = 0; i < 3; i++) begin
      push(32'hE3A01A01, 4, 1'b0, 1'b0);
      step();
    end
    chk("stall_pc", instr_pc, 32'd4);
    stall = 1'b0; fetch_req = 1'b0;
    step();
    chk("after_stall_idle", 32'(instr_valid), 32'd0);

    fetch_req = 1'b1; pc = 4 * DEPTH - 4;
    push(32'h12345678, 4 * DEPTH - 4, 1'b0, 1'b0);
    step();
    pc = 4 * DEPTH;
    push(NOP, 4 * DEPTH, 1'b1, 1'b0);
    step();
    pc = 32'hFFFF_FFF0;
    push(NOP, 32'hFFFF_FFF0, 1'b1, 1'b0);
    step();
    flush = 1'b1; stall = 1'b1; pc = 0;
    step();
    chk("flush_valid", 32'(instr_valid), 32'd0);
    flush = 1'b0; stall = 1'b0;

    pc = 6;
`ifdef IMEM_ALIGN_CHECK_EN
    push(NOP, 6, 1'b0, 1'b1);
`else
    push(32'hE3A01A01, 6, 1'b0, 1'b0);
`endif
    step();

    pc = 0;
    push(32'hE3A00014, 0, 1'b0, 1'b0);
    step();
    pc = 4;
    push(32'hE3A01A01, 4, 1'b0, 1'b0);
    step();

    rst = 1'b0; pc = 0;
    step();
    chk("midrun_rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    step();
    chk("load_again_valid", 32'(instr_valid), 32'd0);
    chk("load_again_ready", 32'(ready), 32'd0);
    fetch_req = 1'b0; load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("ready_again", 32'(ready), 32'd1);
    fetch_req = 1'b1; pc = 0;
    push(32'hE3A00014, 0, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    step();
    step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
